// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues one read per cycle to a synchronous instruction SRAM whose data
// arrives one cycle after the request. The fetched instruction is presented
// to decode straight from the SRAM output (LIVE) or, while decode stalls,
// from an internal copy (HELD). A decode-stage redirect always wins: it
// discards the presented instruction and fetches the target in the same cycle.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  // decode-stage handshake and redirect
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  // instruction SRAM (read-only use)
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  // EMPTY: nothing presented (only right after reset).
  // LIVE : instruction comes from inst_sram_rdata this cycle.
  // HELD : instruction comes from buf_q because decode stalled last cycle.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LIVE  = 2'd1,
    S_HELD  = 2'd2
  } fs_state_e;

  fs_state_e   state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] buf_q,   buf_d;
  logic        pend_q,  pend_d;   // first fetch after reset still outstanding

  logic        fs_valid;
  logic        accept;
  logic        issue;
  logic [31:0] seq_pc;
  logic [31:0] fetch_addr;

  // Handshake terms and the address of the fetch issued this cycle.
  always_comb begin
    fs_valid   = (state_q != S_EMPTY);
    accept     = fs_valid & ds_allowin;
    issue      = ~reset & ((state_q == S_EMPTY) | accept | br_taken);
    seq_pc     = pc_q + 32'd4;    // wraps modulo 2^32, carry discarded
    fetch_addr = br_taken ? br_target : (pend_q ? RESET_PC : seq_pc);
  end

  // Next-state: any issue makes the new fetch LIVE next cycle; a stalled
  // LIVE instruction is copied into the buffer before the SRAM output moves on.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    pend_d  = pend_q;
    if (issue) begin
      state_d = S_LIVE;
      pc_d    = fetch_addr;
      pend_d  = 1'b0;
    end else if (state_q == S_LIVE) begin
      state_d = S_HELD;
      buf_d   = inst_sram_rdata;
    end
  end

  // State registers; reset aborts any in-flight or held instruction.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_EMPTY;
      pc_q    <= RESET_PC - 32'd4;
      buf_q   <= 32'd0;
      pend_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
    end
  end

  // Presented instruction selects the live SRAM word or the held copy.
  always_comb begin
    fs_to_ds_valid = fs_valid;
    fs_pc          = pc_q;
    case (state_q)
      S_LIVE:  fs_inst = inst_sram_rdata;
      S_HELD:  fs_inst = buf_q;
      default: fs_inst = 32'd0;
    endcase
  end

  // SRAM request: read-only port.
  always_comb begin
    inst_sram_en    = issue;
    inst_sram_we    = 1'b0;
    inst_sram_addr  = fetch_addr;
    inst_sram_wdata = 32'd0;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a one-cycle-latency SRAM model feeds the
// stage, directed steps check fetch addresses, and a scoreboard queue holds
// the PCs expected to be handed off to decode, popped at each hand-off.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'd0;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic        garbage = 1'b0;
  logic [31:0] junk = 32'hdead_0000;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address, with one known word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0004) return 32'h0280_0421;
    return {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
  endfunction

  // SRAM model: data one cycle after the request; when garbage is set the
  // output keeps changing on idle cycles.
  always @(posedge clk) begin
    if (inst_sram_en) begin
      inst_sram_rdata <= mem_word(inst_sram_addr);
    end else if (garbage) begin
      inst_sram_rdata <= junk;
      junk            <= junk + 32'h1111_1111;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs (called just after a falling edge) and let them settle.
  task automatic drive(input logic allow, input logic br, input logic [31:0] tgt);
    ds_allowin = allow;
    br_taken   = br;
    br_target  = tgt;
    #1;
  endtask

  // Score a hand-off if one happens this cycle, then move to the next cycle.
  task automatic advance();
    logic [31:0] e;
    if (fs_to_ds_valid && ds_allowin && !br_taken) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL handoff_unexpected: observed pc %h expected no hand-off", fs_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("handoff_pc", fs_pc, e);
        check("handoff_inst", fs_inst, mem_word(e));
      end
    end
    @(negedge clk);
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] addr);
    check({tag, "_en"}, 32'(inst_sram_en), 32'd1);
    check({tag, "_addr"}, inst_sram_addr, addr);
  endtask

  initial begin
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check("rst_valid", 32'(fs_to_ds_valid), 32'd0);
    check("rst_en", 32'(inst_sram_en), 32'd0);
    check("rst_pc", fs_pc, RESET_PC - 32'd4);
    check("rst_we", 32'(inst_sram_we), 32'd0);
    check("rst_wdata", inst_sram_wdata, 32'd0);

    // C0: release, EMPTY issues RESET_PC
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    check("c0_valid", 32'(fs_to_ds_valid), 32'd0);
    check_fetch("c0", 32'h1c00_0000);
    exp_q.push_back(32'h1c00_0000);
    advance();

    // C1: RESET_PC presented and accepted, next sequential fetched
    drive(1'b1, 1'b0, 32'd0);
    check("c1_valid", 32'(fs_to_ds_valid), 32'd1);
    check("c1_pc", fs_pc, 32'h1c00_0000);
    check_fetch("c1", 32'h1c00_0004);
    exp_q.push_back(32'h1c00_0004);
    advance();

    // C2..C4: stall three cycles on 1c000004, SRAM output turns to garbage
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      garbage = 1'b1;
      check("stall_valid", 32'(fs_to_ds_valid), 32'd1);
      check("stall_pc", fs_pc, 32'h1c00_0004);
      check("stall_inst", fs_inst, 32'h0280_0421);
      check("stall_en", 32'(inst_sram_en), 32'd0);
      advance();
    end

    // C5: release, held word handed off, 1c000008 issued
    garbage = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    check("c5_inst", fs_inst, 32'h0280_0421);
    check_fetch("c5", 32'h1c00_0008);
    advance();

    // C6: redirect while 1c000008 is presented; it must not be handed off
    drive(1'b1, 1'b1, 32'h1c00_0100);
    check("c6_pc", fs_pc, 32'h1c00_0008);
    check_fetch("c6", 32'h1c00_0100);
    exp_q.push_back(32'h1c00_0100);
    advance();

    // C7: branch target presented
    drive(1'b1, 1'b0, 32'd0);
    check("c7_pc", fs_pc, 32'h1c00_0100);
    check_fetch("c7", 32'h1c00_0104);
    advance();

    // C8: stall in LIVE -> HELD next
    drive(1'b0, 1'b0, 32'd0);
    check("c8_en", 32'(inst_sram_en), 32'd0);
    advance();

    // C9: redirect in HELD with ds_allowin=0
    drive(1'b0, 1'b1, 32'h1c00_0200);
    check("c9_inst", fs_inst, mem_word(32'h1c00_0104));
    check_fetch("c9", 32'h1c00_0200);
    exp_q.push_back(32'h1c00_0200);
    advance();

    // C10: target LIVE, held word discarded
    drive(1'b1, 1'b0, 32'd0);
    check("c10_valid", 32'(fs_to_ds_valid), 32'd1);
    check("c10_pc", fs_pc, 32'h1c00_0200);
    advance();

    // C11..C13: wrap-around from fffffffc to 00000000
    drive(1'b1, 1'b1, 32'hffff_fffc);
    check_fetch("c11", 32'hffff_fffc);
    exp_q.push_back(32'hffff_fffc);
    advance();
    drive(1'b1, 1'b0, 32'd0);
    check("c12_pc", fs_pc, 32'hffff_fffc);
    check_fetch("wrap", 32'h0000_0000);
    exp_q.push_back(32'h0000_0000);
    advance();
    drive(1'b1, 1'b0, 32'd0);
    check("c13_pc", fs_pc, 32'h0000_0000);
    check_fetch("c13", 32'h0000_0004);
    advance();

    // C14..C15: stall on 00000004, then reset mid-stall with no clock edge
    drive(1'b0, 1'b0, 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'd0);
    check("c15_valid", 32'(fs_to_ds_valid), 32'd1);
    check("c15_inst", fs_inst, mem_word(32'h0000_0004));
    reset = 1'b1;
    #1;
    check("async_valid", 32'(fs_to_ds_valid), 32'd0);
    check("async_en", 32'(inst_sram_en), 32'd0);
    check("async_pc", fs_pc, RESET_PC - 32'd4);
    @(negedge clk);
    @(negedge clk);

    // Restart after release
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    check("rr_valid", 32'(fs_to_ds_valid), 32'd0);
    check_fetch("rr", 32'h1c00_0000);
    exp_q.push_back(32'h1c00_0000);
    advance();
    drive(1'b0, 1'b0, 32'd0);
    check("rr_pc", fs_pc, 32'h1c00_0000);
    check("rr_inst", fs_inst, mem_word(32'h1c00_0000));
    drive(1'b1, 1'b0, 32'd0);
    advance();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c00_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ds_allowin  input  1  decode stage accepts the current instruction this cycle.
REQ-005 SHALL have port br_taken  input  1  decode-stage redirect request, one-cycle pulse.
REQ-006 SHALL have port br_target  input  32  redirect address, valid when br_taken=1.
REQ-007 SHALL have port fs_to_ds_valid  output  1  fs_pc/fs_inst hold a live instruction.
REQ-008 SHALL have port fs_pc  output  32  PC of the instruction presented.
REQ-009 SHALL have port fs_inst  output  32  instruction word presented.
REQ-010 SHALL have port inst_sram_en  output  1  read request this cycle.
REQ-011 SHALL have port inst_sram_we  output  1  constant 0.
REQ-012 SHALL have port inst_sram_addr  output  32  read address.
REQ-013 SHALL have port inst_sram_wdata  output  32  constant 0.
REQ-014 SHALL have port inst_sram_rdata  input  32  read data, valid exactly one cycle after the request.

Function
REQ-015 SHALL implement three states: EMPTY (no instruction), LIVE (instruction taken from inst_sram_rdata this cycle), HELD (instruction taken from an internal 32-bit buffer).
REQ-016 SHALL drive fs_to_ds_valid=1 in LIVE and HELD and 0 in EMPTY.
REQ-017 SHALL drive fs_inst=inst_sram_rdata in LIVE and fs_inst=buffer in HELD.
REQ-018 SHALL define accept = fs_to_ds_valid & ds_allowin.
REQ-019 SHALL define issue = ~reset & (state==EMPTY | accept | br_taken).
REQ-020 SHALL drive inst_sram_en = issue.
REQ-021 SHALL drive inst_sram_addr = br_taken ? br_target : (fetch pending from reset ? RESET_PC : fs_pc+4), with 32-bit wrap-around on +4 and no carry-out.
REQ-022 SHALL, on every issue, load fs_pc with inst_sram_addr and enter LIVE on the next cycle.
REQ-023 SHALL, in LIVE with ds_allowin=0 and br_taken=0, capture inst_sram_rdata into the buffer and enter HELD; fs_pc SHALL be unchanged.
REQ-024 SHALL, in HELD with ds_allowin=0 and br_taken=0, hold state, buffer and fs_pc, and keep inst_sram_en=0.
REQ-025 SHALL give br_taken priority over accept and stall: the presented instruction SHALL be discarded without hand-off, and br_target SHALL be issued in the same cycle, whatever the value of ds_allowin.
REQ-026 SHALL complete the hand-off on accept, and SHALL present the next sequential PC one cycle later, giving one instruction per cycle under continuous ds_allowin=1.
REQ-027 SHALL leave EMPTY only by issuing a fetch; the only EMPTY cycle is the first cycle after reset release.
REQ-028 SHALL treat the latency from issue to fs_to_ds_valid as exactly one cycle.
REQ-029 SHALL NOT leave an unfetched hole on a simultaneous accept and br_taken: the redirect wins and the accepted instruction is not counted as handed off.

Reset
REQ-030 SHALL, while reset=1 (asynchronously), force state=EMPTY, fs_to_ds_valid=0, inst_sram_en=0, fs_pc=RESET_PC-4, buffer=0, and set the from-reset pending flag.
REQ-031 SHALL, on the first edge after reset deasserts, issue RESET_PC, clear the pending flag, and present RESET_PC in the following cycle.
REQ-032 SHALL abort any in-flight fetch or HELD instruction when reset is asserted mid-operation; no stale instruction SHALL appear after release.

Verification
REQ-033 Reset release with ds_allowin=1 held -> inst_sram_en=1 with addr 1c000000, then 1c000004 and 1c000008 on consecutive cycles; fs_pc follows one cycle later with fs_to_ds_valid=1.
REQ-034 Stall: ds_allowin=0 for 3 cycles while fs_pc=1c000004 and rdata=02800421 -> fs_inst stays 02800421 (HELD), inst_sram_en=0, and the rdata input is changed to garbage without effect; on release 1c000008 is issued.
REQ-035 Redirect: br_taken=1 with br_target=1c000100 while fs_pc=1c000008 -> addr=1c000100 that cycle, 1c000008 is never accepted, and the next presented fs_pc is 1c000100.
REQ-036 Simultaneous br_taken=1 and ds_allowin=0 in HELD -> buffer discarded, br_target issued, LIVE next cycle.
REQ-037 Wrap: force fs_pc=fffffffc and accept -> next addr=00000000.
REQ-038 Assert reset asynchronously mid-stall -> fs_to_ds_valid drops immediately without a clock edge; after release the fetch restarts at 1c000000.
